// File: rtl/output_forward_mac.sv
// ---------------------------------------------------------------------------
// output_forward_mac
//   Forward-pass output neuron. Multiplies N_HIDDEN hidden activations by
//   their output-layer weights, one beat per cycle, and accumulates into an
//   unsigned saturating ACC_W-bit result. The result is held on final_o with
//   final_valid_o high until the downstream backprop stage takes it.
//
// Ports
//   clk_i           in   clock, rising edge
//   rst_i           in   asynchronous reset, active-low
//   clear_i         in   synchronous abort: back to IDLE, zero all datapath state
//   start_i         in   one-cycle pulse, begins an inference (IDLE only)
//   hidden_val_i    in   hidden activation for the current beat
//   hidden_valid_i  in   hidden_val_i is valid
//   hidden_ready_o  out  beat can be accepted (ACCUM only)
//   w_idx_o         out  index of the weight expected on w_i this cycle
//   w_i             in   weight selected by w_idx_o, sampled with the beat
//   final_o         out  accumulated result
//   final_valid_o   out  result available (HOLD only)
//   final_ready_i   in   consumer takes the result
//   busy_o          out  ACCUM or HOLD
//   ovf_o           out  sticky saturation flag for the current inference
//
// N_HIDDEN must be >= 1 and fit in IDX_W bits; ACC_W+1 must be at least
// HID_W+WT_W so the product is never truncated before the add.
// ---------------------------------------------------------------------------
module output_forward_mac #(
  parameter int N_HIDDEN = 4,
  parameter int HID_W    = 10,
  parameter int WT_W     = 8,
  parameter int ACC_W    = 23,
  parameter int IDX_W    = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [HID_W-1:0] hidden_val_i,
  input  logic             hidden_valid_i,
  output logic             hidden_ready_o,
  output logic [IDX_W-1:0] w_idx_o,
  input  logic [WT_W-1:0]  w_i,
  output logic [ACC_W-1:0] final_o,
  output logic             final_valid_o,
  input  logic             final_ready_i,
  output logic             busy_o,
  output logic             ovf_o
);

  localparam int             PROD_W   = HID_W + WT_W;
  localparam int             SUM_W    = ACC_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_HIDDEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [ACC_W-1:0]   r_acc;
  logic [IDX_W-1:0]   r_idx;
  logic [ACC_W-1:0]   r_final;
  logic               r_ovf;

  logic [PROD_W-1:0]  w_prod;
  logic [SUM_W-1:0]   w_sum;
  logic [ACC_W-1:0]   w_acc_next;
  logic               w_sat;
  logic               w_beat;
  logic               w_last;

  // One spare bit above the accumulator catches the carry out for saturation.
  assign w_prod     = PROD_W'(hidden_val_i) * PROD_W'(w_i);
  assign w_sum      = {1'b0, r_acc} + SUM_W'(w_prod);
  assign w_sat      = w_sum[ACC_W];
  assign w_acc_next = w_sat ? '1 : w_sum[ACC_W-1:0];

  assign w_beat = hidden_valid_i && (r_state == S_ACCUM);
  assign w_last = (r_idx == LAST_IDX);

  // Handshake flags are decoded straight from state so that reset drops
  // them asynchronously along with the state register.
  assign hidden_ready_o = (r_state == S_ACCUM);
  assign final_valid_o  = (r_state == S_HOLD);
  assign busy_o         = (r_state != S_IDLE);
  assign w_idx_o        = r_idx;
  assign final_o        = r_final;
  assign ovf_o          = r_ovf;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: the default assignment first keeps this block free of latches on
  // any path that does not explicitly set the next state.
  always_comb begin
    w_next_state = r_state;
    if (clear_i) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start_i)          w_next_state = S_ACCUM;
        S_ACCUM: if (w_beat && w_last) w_next_state = S_HOLD;
        S_HOLD:  if (final_ready_i)    w_next_state = S_IDLE;
        default:                       w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_acc   <= '0;
      r_idx   <= '0;
      r_final <= '0;
      r_ovf   <= 1'b0;
    end else if (clear_i) begin
      r_acc   <= '0;
      r_idx   <= '0;
      r_final <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // final_o keeps the previous result visible until a new one lands.
          if (start_i) begin
            r_acc <= '0;
            r_idx <= '0;
            r_ovf <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (w_beat) begin
            r_acc <= w_acc_next;
            r_ovf <= r_ovf | w_sat;
            if (w_last) begin
              r_idx   <= '0;
              r_final <= w_acc_next;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          // HOLD: everything frozen until the result is taken.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_forward_mac.sv
// ---------------------------------------------------------------------------
// tb_output_forward_mac
//   Directed bench for output_forward_mac. Two instances share stimulus: the
//   default ACC_W=23 one and an ACC_W=18 one for the saturation case. Each
//   run pushes hand-computed results into per-instance queues; independent
//   monitors pop and compare whenever final_valid_o rises and keep comparing
//   while it stays high. The driver checks handshake, index and reset
//   behaviour inline.
// ---------------------------------------------------------------------------
module tb_output_forward_mac;

  typedef struct packed {
    logic [31:0] acc;
    logic        ovf;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        start_i = 1'b0;
  logic [9:0]  hidden_val_i = '0;
  logic        hidden_valid_i = 1'b0;
  logic        final_ready_i = 1'b0;

  logic [7:0]  wmem [4];
  logic [9:0]  hmem [4];

  // main instance (ACC_W = 23)
  logic        m_ready, m_valid, m_busy, m_ovf;
  logic [1:0]  m_idx;
  logic [7:0]  m_w;
  logic [22:0] m_final;
  // saturation instance (ACC_W = 18)
  logic        s_ready, s_valid, s_busy, s_ovf;
  logic [1:0]  s_idx;
  logic [7:0]  s_w;
  logic [17:0] s_final;

  // Combinational weight store indexed by each instance's own w_idx_o.
  assign m_w = wmem[m_idx];
  assign s_w = wmem[s_idx];

  int checks = 0;
  int errors = 0;
  exp_t q_m[$];
  exp_t q_s[$];

  always #5 clk_i = ~clk_i;

  output_forward_mac u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .hidden_val_i(hidden_val_i), .hidden_valid_i(hidden_valid_i),
    .hidden_ready_o(m_ready), .w_idx_o(m_idx), .w_i(m_w),
    .final_o(m_final), .final_valid_o(m_valid), .final_ready_i(final_ready_i),
    .busy_o(m_busy), .ovf_o(m_ovf)
  );

  output_forward_mac #(.ACC_W(18)) u_sat (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .hidden_val_i(hidden_val_i), .hidden_valid_i(hidden_valid_i),
    .hidden_ready_o(s_ready), .w_idx_o(s_idx), .w_i(s_w),
    .final_o(s_final), .final_valid_o(s_valid), .final_ready_i(final_ready_i),
    .busy_o(s_busy), .ovf_o(s_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load(input logic [9:0] h0, h1, h2, h3, input logic [7:0] w0, w1, w2, w3);
    hmem[0] = h0; hmem[1] = h1; hmem[2] = h2; hmem[3] = h3;
    wmem[0] = w0; wmem[1] = w1; wmem[2] = w2; wmem[3] = w3;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("ready_after_start", {31'd0, m_ready}, 32'd1);
    check("idx_after_start", {30'd0, m_idx}, 32'd0);
  endtask

  task automatic do_beat(input int i);
    check("w_idx_seq", {30'd0, m_idx}, i);
    hidden_valid_i = 1'b1;
    hidden_val_i   = hmem[i];
    tick();
    hidden_valid_i = 1'b0;
    hidden_val_i   = '0;
  endtask

  // Full inference: start, four beats with an optional gap before beat
  // gap_at, then checks final_valid_o appears exactly after the last beat.
  task automatic run_vec(input logic [31:0] exp_m, input logic ovf_m,
                         input logic [31:0] exp_s, input logic ovf_s,
                         input int gap_at, input int gap_len);
    q_m.push_back('{acc: exp_m, ovf: ovf_m});
    q_s.push_back('{acc: exp_s, ovf: ovf_s});
    do_start();
    for (int i = 0; i < 4; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          tick();
          check("gap_idx_hold", {30'd0, m_idx}, i);
          check("gap_ready", {31'd0, m_ready}, 32'd1);
        end
      end
      do_beat(i);
      if (i < 3) check("valid_not_early", {31'd0, m_valid}, 32'd0);
    end
    check("valid_after_last_beat", {31'd0, m_valid}, 32'd1);
    check("idx_wrap_in_hold", {30'd0, m_idx}, 32'd0);
    check("ready_low_in_hold", {31'd0, m_ready}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  {31'd0, m_busy},  32'd0);
    check({tag, "_ready"}, {31'd0, m_ready}, 32'd0);
    check({tag, "_valid"}, {31'd0, m_valid}, 32'd0);
    check({tag, "_idx"},   {30'd0, m_idx},   32'd0);
    check({tag, "_final"}, {9'd0, m_final},  32'd0);
    check({tag, "_ovf"},   {31'd0, m_ovf},   32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
  endtask

  // Monitors: pop on the rising edge of final_valid_o, compare every cycle
  // the result is held.
  initial begin : mon_main
    exp_t cur;
    logic prev;
    cur = '0;
    prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i && m_valid) begin
        if (!prev) begin
          if (q_m.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL main_unexpected_result: got %0d expected none", m_final);
          end else begin
            cur = q_m.pop_front();
          end
        end
        check("main_final_o", {9'd0, m_final}, cur.acc);
        check("main_ovf_o", {31'd0, m_ovf}, {31'd0, cur.ovf});
      end
      prev = rst_i && m_valid;
    end
  end

  initial begin : mon_sat
    exp_t cur;
    logic prev;
    cur = '0;
    prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i && s_valid) begin
        if (!prev) begin
          if (q_s.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sat_unexpected_result: got %0d expected none", s_final);
          end else begin
            cur = q_s.pop_front();
          end
        end
        check("sat_final_o", {14'd0, s_final}, cur.acc);
        check("sat_ovf_o", {31'd0, s_ovf}, {31'd0, cur.ovf});
      end
      prev = rst_i && s_valid;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    load(10'd1, 10'd2, 10'd3, 10'd4, 8'd10, 8'd20, 8'd30, 8'd40);

    // Reset state
    #1;
    check_all_zero("reset");
    release_reset();
    check("idle_after_reset_busy", {31'd0, m_busy}, 32'd0);

    // 1. back-to-back beats: 10+40+90+160 = 300; final_ready_i held high
    //    throughout (ignored outside HOLD), so HOLD lasts one cycle.
    final_ready_i = 1'b1;
    run_vec(32'd300, 1'b0, 32'd300, 1'b0, -1, 0);
    tick();
    check("t1_idle_after_take", {31'd0, m_busy}, 32'd0);
    check("t1_final_kept_idle", {9'd0, m_final}, 32'd300);

    // 2. three idle cycles before beat 3 (index 2)
    run_vec(32'd300, 1'b0, 32'd300, 1'b0, 2, 3);
    tick();

    // 3. 1023*255 = 260865 per beat: main 1043460, narrow instance saturates
    load(10'd1023, 10'd1023, 10'd1023, 10'd1023, 8'd255, 8'd255, 8'd255, 8'd255);
    run_vec(32'd1043460, 1'b0, 32'd262143, 1'b1, -1, 0);
    tick();
    check("t3_ovf_sticky_idle", {31'd0, s_ovf}, 32'd1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("t3_ovf_cleared_on_start", {31'd0, s_ovf}, 32'd0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("t3_clear_idle", {31'd0, m_busy}, 32'd0);

    // 4. long HOLD: 100*3+200*3+300*3+400*3 = 3000; start and beats ignored
    load(10'd100, 10'd200, 10'd300, 10'd400, 8'd3, 8'd3, 8'd3, 8'd3);
    final_ready_i = 1'b0;
    run_vec(32'd3000, 1'b0, 32'd3000, 1'b0, -1, 0);
    hidden_valid_i = 1'b1;
    hidden_val_i   = 10'd777;
    for (int c = 0; c < 5; c++) begin
      start_i = (c == 1);
      tick();
      check("t4_valid_held", {31'd0, m_valid}, 32'd1);
      check("t4_ready_low", {31'd0, m_ready}, 32'd0);
      check("t4_idx_held", {30'd0, m_idx}, 32'd0);
    end
    start_i = 1'b0;
    hidden_valid_i = 1'b0;
    hidden_val_i = '0;
    final_ready_i = 1'b1;
    tick();
    check("t4_idle_after_ready", {31'd0, m_busy}, 32'd0);
    check("t4_valid_dropped", {31'd0, m_valid}, 32'd0);

    // 5. clear with start on beat 2, then clear+start in IDLE, then a clean run
    load(10'd1, 10'd2, 10'd3, 10'd4, 8'd10, 8'd20, 8'd30, 8'd40);
    do_start();
    do_beat(0);
    hidden_valid_i = 1'b1;
    hidden_val_i   = hmem[1];
    clear_i = 1'b1;
    start_i = 1'b1;
    tick();
    check_all_zero("t5_clear");
    tick();
    check("t5_clear_start_idle", {31'd0, m_busy}, 32'd0);
    clear_i = 1'b0;
    start_i = 1'b0;
    hidden_valid_i = 1'b0;
    hidden_val_i = '0;
    // 5+12+21+32 = 70
    load(10'd5, 10'd6, 10'd7, 10'd8, 8'd1, 8'd2, 8'd3, 8'd4);
    run_vec(32'd70, 1'b0, 32'd70, 1'b0, -1, 0);
    tick();

    // 6. reset mid-ACCUM and mid-HOLD
    load(10'd1, 10'd2, 10'd3, 10'd4, 8'd10, 8'd20, 8'd30, 8'd40);
    do_start();
    do_beat(0);
    do_beat(1);
    rst_i = 1'b0;
    #2;
    check_all_zero("t6_rst_accum");
    release_reset();
    final_ready_i = 1'b0;
    run_vec(32'd300, 1'b0, 32'd300, 1'b0, -1, 0);
    @(negedge clk_i);
    #1;
    rst_i = 1'b0;
    #2;
    check_all_zero("t6_rst_hold");
    release_reset();
    final_ready_i = 1'b1;
    run_vec(32'd300, 1'b0, 32'd300, 1'b0, -1, 0);
    tick();
    tick();
    check("end_idle", {31'd0, m_busy}, 32'd0);
    check("queue_main_drained", q_m.size(), 32'd0);
    check("queue_sat_drained", q_s.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
